out_port_tx: RTL and testbench
==============================

// Module: out_port_tx
// PURPOSE
// - Transmit side of the OUT instruction: takes the 16-bit value the execute stage drives on OUT.
// - Buffers values in a small FIFO and presents them to an external output device over valid/ready.
// - Asserts stall to the hazard unit when the FIFO cannot accept another OUT.
// - Sits after the execute/memory boundary; fed by the pipeline's OUT enable and result bus.
// PARAMETERS
// - DATA_W  16  width of the OUT value / port data
// - DEPTH   4   FIFO entries; power of two, >= 2
// - CNT_W   3   occupancy counter width, = log2(DEPTH)+1
// PORTS
// - clk         in   1       single clock, all state rises on posedge
// - rst_n       in   1       asynchronous, active-low reset
// - out_en      in   1       OUT instruction valid this cycle (write request)
// - out_data    in   DATA_W  value to transmit (Rds passed through OUT unit)
// - stall       out  1       FIFO full; pipeline must hold the OUT instruction
// - port_data   out  DATA_W  head-of-FIFO value to external device
// - port_valid  out  1       port_data valid (FIFO non-empty)
// - port_ready  in   1       external device accepts port_data this cycle
// - fifo_count  out  CNT_W   current occupancy, 0..DEPTH
// - overflow    out  1       sticky: out_en seen while full (write dropped)
// - port_parity out  1       only with OUT_PORT_PARITY_EN, see CONFIGURATION
// BEHAVIOUR
// - Reset (rst_n low, any time, async): wr_ptr=rd_ptr=0, fifo_count=0, port_valid=0,
//   stall=0, overflow=0, port_data=0; storage contents don't care. In-flight data lost.
// - Write: out_en && !full at posedge -> mem[wr_ptr]=out_data, wr_ptr wraps modulo DEPTH.
// - Read: port_valid && port_ready at posedge -> rd_ptr advances modulo DEPTH.
// - port_valid = (fifo_count != 0); port_data = mem[rd_ptr]; both from registered state only.
// - Latency: write at edge N into empty FIFO -> port_valid=1, port_data=value after edge N.
// - No bypass: empty FIFO never forwards out_data combinationally.
// - stall = (fifo_count == DEPTH); registered-state decode, no combinational path from port_ready.
// - Full + out_en: write dropped, overflow set (sticky until reset); stall already high.
// - Full + out_en + port_ready same edge: read only, write dropped, overflow set.
// - Not full, non-empty, out_en + port_ready same edge: both occur, fifo_count unchanged.
// - Empty + port_ready: no effect; port_ready ignored while port_valid=0.
// - port_data/port_valid must hold stable while port_valid=1 && port_ready=0.
// - fifo_count: +1 on write-only, -1 on read-only, unchanged otherwise; never exceeds DEPTH.
// - Pointer widths log2(DEPTH); full/empty from fifo_count, not pointer compare.
// CONFIGURATION
// - OUT_PORT_PARITY_EN defined: port_parity port exists, = ^port_data (even parity, combinational
//   from head entry); 0 when port_valid=0.
// - OUT_PORT_PARITY_EN undefined: port_parity port absent; all other behaviour identical.
// TESTING
// - Reset: rst_n=0 mid-traffic with 3 entries -> same cycle port_valid=0, fifo_count=0, stall=0.
// - Single OUT: out_en=1, out_data=16'hA5C3, port_ready=0 -> next cycle port_valid=1,
//   port_data=A5C3, count=1; held over 5 cycles; port_ready=1 one cycle -> count=0, valid=0.
// - Fill: 4 writes 0001..0004, port_ready=0 -> count=4, stall=1; 5th write 0005 -> dropped,
//   overflow=1; drain -> 0001,0002,0003,0004 in order, stall drops after first read.
// - Simultaneous: count=2, out_en+port_ready same edge -> count stays 2, order preserved;
//   full + both -> count=3, overflow=1.
// - Wrap: 10 writes / 10 reads interleaved, random port_ready -> output sequence equals input
//   sequence, pointers wrap twice, no loss, overflow stays 0.
// - Parity (macro on): port_data=16'h0007 -> port_parity=1; 16'h0003 -> 0; empty -> 0.

Source files
------------

// File: rtl/out_port_tx.sv
// rtl/out_port_tx.sv - OUT instruction transmit FIFO with valid/ready output port
//
// Purpose: buffers 16-bit OUT values from the execute stage in a small FIFO and
// presents them to an external device over valid/ready. Raises stall to the
// hazard unit while the FIFO is full.
//
// Optional feature macro: OUT_PORT_PARITY_EN (adds the port_parity output).
//
// Ports:
//   clk          in   1       clock, all state on posedge
//   rst_n        in   1       asynchronous active-low reset
//   out_en       in   1       OUT instruction valid (write request)
//   out_data     in   DATA_W  value to transmit
//   stall        out  1       FIFO full; pipeline must hold the OUT
//   port_data    out  DATA_W  head-of-FIFO value
//   port_valid   out  1       port_data valid (FIFO non-empty)
//   port_ready   in   1       external device accepts port_data
//   fifo_count   out  CNT_W   occupancy 0..DEPTH
//   overflow     out  1       sticky: out_en seen while full
//   port_parity  out  1       even parity of port_data (OUT_PORT_PARITY_EN only)

module out_port_tx #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              out_en,
    input  logic [DATA_W-1:0] out_data,
    output logic              stall,
    output logic [DATA_W-1:0] port_data,
    output logic              port_valid,
    input  logic              port_ready,
    output logic [CNT_W-1:0]  fifo_count,
    output logic              overflow
`ifdef OUT_PORT_PARITY_EN
    ,
    output logic              port_parity
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic              overflow_q;
    logic              full;
    logic              wr_fire;
    logic              rd_fire;

    // Full/empty come from the occupancy counter so the pointers can wrap
    // freely without an extra disambiguation bit.
    assign full       = (count_q == CNT_W'(DEPTH));
    assign stall      = full;
    assign port_valid = (count_q != '0);
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

    assign wr_fire = out_en && !full;
    assign rd_fire = port_valid && port_ready;

    // Storage is not reset, so the head is masked while empty to keep
    // port_data at zero out of reset and whenever nothing is queued.
    assign port_data = port_valid ? mem[rd_ptr] : '0;

`ifdef OUT_PORT_PARITY_EN
    assign port_parity = ^port_data;
`endif

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr] <= out_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_fire, rd_fire})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            // A write attempted while full is dropped; remember it until reset.
            if (out_en && full) begin
                overflow_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_out_port_tx.sv
// tb/tb_out_port_tx.sv - self-checking bench for out_port_tx

module tb_out_port_tx;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        out_en;
    logic [15:0] out_data;
    logic        port_ready;
    logic        stall;
    logic [15:0] port_data;
    logic        port_valid;
    logic [2:0]  fifo_count;
    logic        overflow;
`ifdef OUT_PORT_PARITY_EN
    logic        port_parity;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] mq[$];
    bit          ov_m;

    out_port_tx #(.DATA_W(16), .DEPTH(DEPTH), .CNT_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .out_en     (out_en),
        .out_data   (out_data),
        .stall      (stall),
        .port_data  (port_data),
        .port_valid (port_valid),
        .port_ready (port_ready),
        .fifo_count (fifo_count),
        .overflow   (overflow)
`ifdef OUT_PORT_PARITY_EN
        ,
        .port_parity(port_parity)
`endif
    );

    always #5 clk = ~clk;

    // One clock: reference queue follows the FIFO rules, inputs are sampled
    // as they stand before the edge, outputs are then observed 1 time unit later.
    task automatic cycle();
        bit was_full;
        bit do_rd;
        bit do_wr;
        was_full = (mq.size() == DEPTH);
        do_rd    = port_ready && (mq.size() != 0);
        do_wr    = out_en && !was_full;
        @(posedge clk);
        if (do_rd) void'(mq.pop_front());
        if (do_wr) mq.push_back(out_data);
        if (out_en && was_full) ov_m = 1'b1;
        #1;
    endtask

    task automatic apply_reset();
        out_en     = 1'b0;
        port_ready = 1'b0;
        rst_n      = 1'b0;
        mq.delete();
        ov_m = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        out_en = 1'b0; port_ready = 1'b0; out_data = '0; rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (port_valid !== 1'b0 || fifo_count !== 3'd0 || stall !== 1'b0 || overflow !== 1'b0 || port_data !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_init: valid=%b count=%0d stall=%b ovf=%b data=%h, required 0/0/0/0/0000", port_valid, fifo_count, stall, overflow, port_data);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            out_en = 1'b1; out_data = 16'($urandom); cycle();
        end
        out_en = 1'b0;
        n_checks++;
        if (fifo_count !== 3'd3) begin
            n_fail++;
            $display("FAIL reset_preload: count=%0d, required 3", fifo_count);
        end
        // Asynchronous assertion mid-cycle: outputs must clear before any edge.
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (port_valid !== 1'b0 || fifo_count !== 3'd0 || stall !== 1'b0 || port_data !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_async: valid=%b count=%0d stall=%b data=%h, required 0/0/0/0000", port_valid, fifo_count, stall, port_data);
        end
        mq.delete(); ov_m = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        out_en = 1'b1; out_data = 16'hA5C3; port_ready = 1'b0;
        cycle();
        out_en = 1'b0;
        n_checks++;
        if (port_valid !== 1'b1 || port_data !== 16'hA5C3 || fifo_count !== 3'd1) begin
            n_fail++;
            $display("FAIL single_latency: valid=%b data=%h count=%0d, required 1/a5c3/1", port_valid, port_data, fifo_count);
        end
        for (int i = 0; i < 5; i++) begin
            cycle();
            n_checks++;
            if (port_valid !== 1'b1 || port_data !== 16'hA5C3) begin
                n_fail++;
                $display("FAIL single_hold[%0d]: valid=%b data=%h, required 1/a5c3", i, port_valid, port_data);
            end
        end
        port_ready = 1'b1;
        cycle();
        port_ready = 1'b0;
        n_checks++;
        if (port_valid !== 1'b0 || fifo_count !== 3'd0) begin
            n_fail++;
            $display("FAIL single_drain: valid=%b count=%0d, required 0/0", port_valid, fifo_count);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 4; i++) begin
            out_en = 1'b1; out_data = 16'(i); cycle();
        end
        n_checks++;
        if (fifo_count !== 3'd4 || stall !== 1'b1 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_full: count=%0d stall=%b ovf=%b, required 4/1/0", fifo_count, stall, overflow);
        end
        out_data = 16'h0005;
        cycle();
        out_en = 1'b0;
        n_checks++;
        if (fifo_count !== 3'd4 || overflow !== 1'b1 || port_data !== 16'h0001) begin
            n_fail++;
            $display("FAIL fill_overflow: count=%0d ovf=%b head=%h, required 4/1/0001", fifo_count, overflow, port_data);
        end
        for (int i = 1; i <= 4; i++) begin
            n_checks++;
            if (port_valid !== 1'b1 || port_data !== 16'(i)) begin
                n_fail++;
                $display("FAIL fill_drain[%0d]: valid=%b data=%h, required 1/%h", i, port_valid, port_data, 16'(i));
            end
            port_ready = 1'b1;
            cycle();
            if (i == 1) begin
                n_checks++;
                if (stall !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fill_stall_drop: stall=%b, required 0", stall);
                end
            end
        end
        port_ready = 1'b0;
        n_checks++;
        if (fifo_count !== 3'd0 || port_valid !== 1'b0 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_empty: count=%0d valid=%b ovf=%b, required 0/0/1", fifo_count, port_valid, overflow);
        end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            out_en = 1'b1; out_data = 16'($urandom); cycle();
        end
        out_en = 1'b1; out_data = 16'($urandom); port_ready = 1'b1;
        cycle();
        port_ready = 1'b0;
        n_checks++;
        if (fifo_count !== 3'd2 || port_data !== mq[0]) begin
            n_fail++;
            $display("FAIL simul_mid: count=%0d head=%h, required 2/%h", fifo_count, port_data, mq[0]);
        end
        for (int i = 0; i < 2; i++) begin
            out_data = 16'($urandom); cycle();
        end
        out_data = 16'($urandom); port_ready = 1'b1;
        cycle();
        out_en = 1'b0; port_ready = 1'b0;
        n_checks++;
        if (fifo_count !== 3'd3 || overflow !== 1'b1 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_full: count=%0d ovf=%b stall=%b, required 3/1/0", fifo_count, overflow, stall);
        end
        while (mq.size() != 0) begin
            n_checks++;
            if (port_data !== mq[0]) begin
                n_fail++;
                $display("FAIL simul_order: data=%h, required %h", port_data, mq[0]);
            end
            port_ready = 1'b1;
            cycle();
        end
        port_ready = 1'b0;
    endtask

    task automatic test_wrap();
        logic [15:0] sent[$];
        logic [15:0] rcvd[$];
        int          idx;
        int          cyc;
        apply_reset();
        for (int i = 0; i < 10; i++) sent.push_back(16'($urandom));
        idx = 0;
        cyc = 0;
        while ((idx < 10 || mq.size() != 0) && cyc < 300) begin
            out_en     = (idx < 10) && (mq.size() < DEPTH) && ($urandom_range(0, 1) == 1);
            out_data   = (idx < 10) ? sent[idx] : 16'($urandom);
            port_ready = ($urandom_range(0, 1) == 1);
            if (out_en) idx++;
            if (port_valid && port_ready) rcvd.push_back(port_data);
            cycle();
            cyc++;
            n_checks++;
            if (fifo_count !== 3'(mq.size()) || port_valid !== (mq.size() != 0) || stall !== (mq.size() == DEPTH)) begin
                n_fail++;
                $display("FAIL wrap_state: count=%0d valid=%b stall=%b, required count %0d", fifo_count, port_valid, stall, mq.size());
            end
        end
        out_en = 1'b0; port_ready = 1'b0;
        n_checks++;
        if (cyc >= 300) begin
            n_fail++;
            $display("FAIL wrap_timeout: cycles=%0d, required < 300", cyc);
        end
        n_checks++;
        if (rcvd.size() != 10) begin
            n_fail++;
            $display("FAIL wrap_count: received %0d, required 10", rcvd.size());
        end
        for (int i = 0; i < 10 && i < rcvd.size(); i++) begin
            n_checks++;
            if (rcvd[i] !== sent[i]) begin
                n_fail++;
                $display("FAIL wrap_data[%0d]: got %h, required %h", i, rcvd[i], sent[i]);
            end
        end
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_overflow: ovf=%b, required 0", overflow);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 300; c++) begin
            out_en     = ($urandom_range(0, 2) != 0);
            out_data   = 16'($urandom);
            port_ready = ($urandom_range(0, 2) == 0);
            cycle();
            n_checks++;
            if (fifo_count !== 3'(mq.size()) || stall !== (mq.size() == DEPTH) ||
                overflow !== ov_m || (mq.size() != 0 && port_data !== mq[0])) begin
                n_fail++;
                $display("FAIL random[%0d]: count=%0d stall=%b ovf=%b data=%h, required count %0d ovf %b", c, fifo_count, stall, overflow, port_data, mq.size(), ov_m);
            end
        end
        out_en = 1'b0; port_ready = 1'b0;
    endtask

`ifdef OUT_PORT_PARITY_EN
    task automatic test_parity();
        apply_reset();
        n_checks++;
        if (port_parity !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_empty: parity=%b, required 0", port_parity);
        end
        out_en = 1'b1; out_data = 16'h0007; cycle();
        out_en = 1'b0;
        n_checks++;
        if (port_parity !== 1'b1) begin
            n_fail++;
            $display("FAIL parity_0007: parity=%b, required 1", port_parity);
        end
        port_ready = 1'b1; cycle();
        port_ready = 1'b0;
        out_en = 1'b1; out_data = 16'h0003; cycle();
        out_en = 1'b0;
        n_checks++;
        if (port_parity !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_0003: parity=%b, required 0", port_parity);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_simultaneous();
        test_wrap();
        test_random();
`ifdef OUT_PORT_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
